// File: rtl/tank_render_engine.sv
// ============================================================================
// Module  : tank_render_engine
// Brief   : Erases then redraws NUM_TANKS square tank sprites, one pixel per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tank_render_engine #(
    parameter int                  NUM_TANKS = 2,
    parameter int                  SPR       = 4,
    parameter int                  X_W       = 8,
    parameter int                  Y_W       = 7,
    parameter int                  COLOUR_W  = 3,
    parameter int                  H_RES     = 160,
    parameter int                  V_RES     = 120,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_TANKS-1:0]            enable,
    input  logic [NUM_TANKS*X_W-1:0]        pos_x,
    input  logic [NUM_TANKS*Y_W-1:0]        pos_y,
    input  logic [NUM_TANKS*2-1:0]          dir,
    input  logic [NUM_TANKS*COLOUR_W-1:0]   tcolour,
    output logic [X_W-1:0]                  x,
    output logic [Y_W-1:0]                  y,
    output logic [COLOUR_W-1:0]             colour,
    output logic                            plot,
    output logic                            busy,
    output logic                            done
);

    localparam int TW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam int CW = (SPR > 1) ? $clog2(SPR) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_FIN} state_t;

    state_t                r_state;
    logic [NUM_TANKS-1:0]  r_prev_valid;
    logic [NUM_TANKS-1:0]  r_draw_mask;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_row;
    logic                  r_bar;

    logic [X_W-1:0]        r_snap_x [NUM_TANKS];
    logic [Y_W-1:0]        r_snap_y [NUM_TANKS];
    logic [1:0]            r_snap_d [NUM_TANKS];
    logic [COLOUR_W-1:0]   r_snap_c [NUM_TANKS];
    logic [X_W-1:0]        r_prev_x [NUM_TANKS];
    logic [Y_W-1:0]        r_prev_y [NUM_TANKS];
    logic [1:0]            r_prev_d [NUM_TANKS];

    function automatic logic [TW-1:0] lowest(input logic [NUM_TANKS-1:0] m);
        lowest = '0;
        for (int i = NUM_TANKS - 1; i >= 0; i--)
            if (m[i]) lowest = TW'(i);
    endfunction

    logic                  w_erase;
    logic [NUM_TANKS-1:0]  w_mask;
    logic [TW-1:0]         w_t;
    logic [NUM_TANKS-1:0]  w_onehot;
    logic [X_W-1:0]        w_ox;
    logic [Y_W-1:0]        w_oy;
    logic [1:0]            w_dir;
    logic [X_W:0]          w_dx;
    logic [Y_W:0]          w_dy;
    logic [X_W:0]          w_px;
    logic [Y_W:0]          w_py;
    logic                  w_vis;

    // The tank being serviced is always the lowest pending bit, so idle channels cost no cycles.
    assign w_erase = (r_state == S_ERASE);
    assign w_mask  = w_erase ? r_prev_valid : r_draw_mask;
    assign w_t     = lowest(w_mask);
    assign w_ox    = w_erase ? r_prev_x[w_t] : r_snap_x[w_t];
    assign w_oy    = w_erase ? r_prev_y[w_t] : r_snap_y[w_t];
    assign w_dir   = w_erase ? r_prev_d[w_t] : r_snap_d[w_t];

    always_comb begin
        w_onehot      = '0;
        w_onehot[w_t] = 1'b1;
    end

    // Offsets are one bit wider than the screen so that -1 wraps above any legal coordinate.
    always_comb begin
        w_dx = (X_W+1)'(r_col);
        w_dy = (Y_W+1)'(r_row);
        if (r_bar) begin
            case (w_dir)
                2'd0:    begin w_dx = (X_W+1)'(SPR/2); w_dy = '1;               end
                2'd1:    begin w_dx = (X_W+1)'(SPR);   w_dy = (Y_W+1)'(SPR/2);  end
                2'd2:    begin w_dx = (X_W+1)'(SPR/2); w_dy = (Y_W+1)'(SPR);    end
                default: begin w_dx = '1;              w_dy = (Y_W+1)'(SPR/2);  end
            endcase
        end
    end

    assign w_px  = {1'b0, w_ox} + w_dx;
    assign w_py  = {1'b0, w_oy} + w_dy;
    assign w_vis = (w_px < (X_W+1)'(H_RES)) && (w_py < (Y_W+1)'(V_RES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_prev_valid <= '0;
            r_draw_mask  <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_bar        <= 1'b0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < NUM_TANKS; i++) begin
                            r_snap_x[i] <= pos_x[i*X_W +: X_W];
                            r_snap_y[i] <= pos_y[i*Y_W +: Y_W];
                            r_snap_d[i] <= dir[i*2 +: 2];
                            r_snap_c[i] <= tcolour[i*COLOUR_W +: COLOUR_W];
                        end
                        r_draw_mask <= enable;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_bar       <= 1'b0;
                        busy        <= 1'b1;
                        if (r_prev_valid != '0)  r_state <= S_ERASE;
                        else if (enable != '0)   r_state <= S_DRAW;
                        else                     r_state <= S_FIN;
                    end
                end
                S_ERASE, S_DRAW: begin
                    x      <= w_px[X_W-1:0];
                    y      <= w_py[Y_W-1:0];
                    colour <= w_erase ? BG_COLOUR : r_snap_c[w_t];
                    plot   <= w_vis;
                    if (r_bar) begin
                        r_bar <= 1'b0;
                        r_col <= '0;
                        r_row <= '0;
                        if (w_erase) begin
                            r_prev_valid[w_t] <= 1'b0;
                            if ((r_prev_valid & ~w_onehot) == '0)
                                r_state <= (r_draw_mask != '0) ? S_DRAW : S_FIN;
                        end else begin
                            r_draw_mask[w_t]  <= 1'b0;
                            r_prev_valid[w_t] <= 1'b1;
                            r_prev_x[w_t]     <= r_snap_x[w_t];
                            r_prev_y[w_t]     <= r_snap_y[w_t];
                            r_prev_d[w_t]     <= r_snap_d[w_t];
                            if ((r_draw_mask & ~w_onehot) == '0)
                                r_state <= S_FIN;
                        end
                    end else if (r_col == CW'(SPR-1)) begin
                        r_col <= '0;
                        if (r_row == CW'(SPR-1)) r_bar <= 1'b1;
                        else                     r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: begin
                    plot    <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
